// File: rtl/me_iddmm_pkg.sv
// rtl/me_iddmm_pkg.sv - controller state encoding and config bank select codes
package me_iddmm_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD_X,
      S_MX_RUN,
      S_SQ_WR,
      S_SQ_RUN,
      S_ML_WR,
      S_ML_RUN,
      S_FIN_WR,
      S_FIN_RUN
   } me_state_e;

   localparam logic [1:0] CFG_M   = 2'd0;
   localparam logic [1:0] CFG_ROU = 2'd1;
   localparam logic [1:0] CFG_ONE = 2'd2;
   localparam logic [1:0] CFG_Y   = 2'd3;

endpackage

// File: rtl/me_word_bank.sv
// rtl/me_word_bank.sv - N x K word register bank, one write port, one combinational read port
module me_word_bank #(
   parameter int K      = 128,
   parameter int N      = 16,
   parameter int ADDR_W = $clog2(N)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [K-1:0]      wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [K-1:0]      rd_data
);

   logic [K-1:0] mem_q [N];
   logic [K-1:0] mem_d [N];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[wr_addr] = wr_data;
   end

   // Contents are deliberately not reset; software reloads banks after reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mmp_iddmm_sp.sv
// rtl/mmp_iddmm_sp.sv - word-serial Montgomery multiplier: res = x*y*2^(-K*N) mod m
module mmp_iddmm_sp #(
   parameter int K      = 128,
   parameter int N      = 16,
   parameter int ADDR_W = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        wr_ena,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [K-1:0]      wr_x,
   input  logic [K-1:0]      wr_y,
   input  logic [K-1:0]      wr_m,
   input  logic [K-1:0]      wr_m1,
   input  logic              task_req,
   output logic              task_grant,
   output logic              task_end,
   output logic [K-1:0]      task_res
);

   localparam int W  = K * N;
   localparam int TW = W + K + 2;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

   typedef enum logic [1:0] {E_IDLE, E_CALC, E_OUT} eng_state_e;

   logic [W-1:0]      x_q, x_d, y_q, y_d, m_q, m_d;
   logic [K-1:0]      m1_q, m1_d;
   eng_state_e        st_q, st_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [TW-1:0]     t_q, t_d;
   logic [K-1:0]      yw, q;
   logic [TW-1:0]     s, u, tn;

   always_comb begin
      x_d  = x_q;
      y_d  = y_q;
      m_d  = m_q;
      m1_d = m1_q;
      if (wr_ena[0]) x_d[K*int'(wr_addr) +: K] = wr_x;
      if (wr_ena[1]) y_d[K*int'(wr_addr) +: K] = wr_y;
      if (wr_ena[2]) begin
         m_d[K*int'(wr_addr) +: K] = wr_m;
         m1_d = wr_m1;
      end
   end

   // One radix-2^K step: q clears the low word so the shift by K is exact.
   always_comb begin
      yw = y_q[K*int'(cnt_q) +: K];
      s  = t_q + TW'(x_q) * TW'(yw);
      q  = s[K-1:0] * m1_q;
      u  = s + TW'(m_q) * TW'(q);
      tn = u >> K;
   end

   always_comb begin
      st_d       = st_q;
      cnt_d      = cnt_q;
      t_d        = t_q;
      task_grant = 1'b0;
      task_end   = 1'b0;
      task_res   = t_q[K*int'(cnt_q) +: K];
      case (st_q)
         E_IDLE: begin
            if (task_req) begin
               st_d  = E_CALC;
               cnt_d = '0;
               t_d   = '0;
            end
         end
         E_CALC: begin
            t_d   = tn;
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST) begin
               cnt_d = '0;
               st_d  = E_OUT;
               if (tn >= TW'(m_q)) t_d = tn - TW'(m_q);
            end
         end
         E_OUT: begin
            task_grant = 1'b1;
            cnt_d      = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST) begin
               task_end = 1'b1;
               cnt_d    = '0;
               st_d     = E_IDLE;
            end
         end
         default: st_d = E_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      x_q  <= x_d;
      y_q  <= y_d;
      m_q  <= m_d;
      m1_q <= m1_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= E_IDLE;
         cnt_q <= '0;
         t_q   <= '0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         t_q   <= t_d;
      end
   end

endmodule

// File: rtl/me_iddmm_rt.sv
// rtl/me_iddmm_rt.sv - runtime-configured x^y mod m controller over mmp_iddmm_sp
// ME_CONST_TIME_EN: multiply on every exponent bit, discarding into a scratch bank when the bit is 0.
module me_iddmm_rt
   import me_iddmm_pkg::*;
#(
   parameter int K      = 128,
   parameter int N      = 16,
   parameter int ADDR_W = $clog2(N),
   parameter int EB_W   = $clog2(K*N) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_wr_en,
   input  logic [1:0]        cfg_sel,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [K-1:0]      cfg_data,
   input  logic [K-1:0]      cfg_m1,
   input  logic [EB_W-1:0]   cfg_ebits,
   input  logic              me_start,
   output logic              me_busy,
   input  logic [K-1:0]      me_x,
   input  logic              me_x_valid,
   output logic              me_x_ready,
   output logic [K-1:0]      me_result,
   output logic              me_valid,
   output logic              me_last
);

   localparam int KB = $clog2(K);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

   me_state_e         state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [EB_W-1:0]   idx_q, idx_d, ebits_q, ebits_d;
   logic [K-1:0]      m1_q, m1_d, result_q, result_d;
   logic              acc_one_q, acc_one_d, valid_q, valid_d, last_q, last_d;

   logic [K-1:0]      m_rd, rou_rd, one_rd, y_rd, xr_rd, acc_rd, acc_word;
   logic              cfg_we, acc_we, next_bit, ybit;
   logic [2:0]        eng_wr_ena;
   logic [K-1:0]      eng_wr_x, eng_wr_y, eng_task_res;
   logic              eng_task_req, eng_task_grant, eng_task_end;

   assign me_busy    = (state_q != S_IDLE) | valid_q;
   assign me_x_ready = (state_q == S_LOAD_X);
   assign me_result  = result_q;
   assign me_valid   = valid_q;
   assign me_last    = last_q;
   assign cfg_we     = cfg_wr_en & ~me_busy;
   assign ybit       = y_rd[idx_q[KB-1:0]];
   // acc_one_q aliases acc onto the one bank until the first square lands, avoiding an N-cycle copy.
   assign acc_word   = acc_one_q ? one_rd : acc_rd;

   me_word_bank #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_m_bank (
      .clk(clk), .wr_en(cfg_we && cfg_sel == CFG_M), .wr_addr(cfg_addr), .wr_data(cfg_data),
      .rd_addr(cnt_q), .rd_data(m_rd));
   me_word_bank #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_rou_bank (
      .clk(clk), .wr_en(cfg_we && cfg_sel == CFG_ROU), .wr_addr(cfg_addr), .wr_data(cfg_data),
      .rd_addr(cnt_q), .rd_data(rou_rd));
   me_word_bank #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_one_bank (
      .clk(clk), .wr_en(cfg_we && cfg_sel == CFG_ONE), .wr_addr(cfg_addr), .wr_data(cfg_data),
      .rd_addr(cnt_q), .rd_data(one_rd));
   me_word_bank #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_y_bank (
      .clk(clk), .wr_en(cfg_we && cfg_sel == CFG_Y), .wr_addr(cfg_addr), .wr_data(cfg_data),
      .rd_addr(ADDR_W'(idx_q >> KB)), .rd_data(y_rd));
   me_word_bank #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_xr_bank (
      .clk(clk), .wr_en(state_q == S_MX_RUN && eng_task_grant), .wr_addr(cnt_q),
      .wr_data(eng_task_res), .rd_addr(cnt_q), .rd_data(xr_rd));
   me_word_bank #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_acc_bank (
      .clk(clk), .wr_en(acc_we), .wr_addr(cnt_q), .wr_data(eng_task_res),
      .rd_addr(cnt_q), .rd_data(acc_rd));

`ifdef ME_CONST_TIME_EN
   logic         ybit_q, ybit_d, scr_we;
   logic [K-1:0] scr_rd;

   me_word_bank #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_scr_bank (
      .clk(clk), .wr_en(scr_we), .wr_addr(cnt_q), .wr_data(eng_task_res),
      .rd_addr(cnt_q), .rd_data(scr_rd));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ybit_q <= 1'b0;
      else        ybit_q <= ybit_d;
   end
`endif

   mmp_iddmm_sp #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_engine (
      .clk(clk), .rst_n(rst_n), .wr_ena(eng_wr_ena), .wr_addr(cnt_q),
      .wr_x(eng_wr_x), .wr_y(eng_wr_y), .wr_m(m_rd), .wr_m1(m1_q),
      .task_req(eng_task_req), .task_grant(eng_task_grant), .task_end(eng_task_end),
      .task_res(eng_task_res));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      ebits_d      = ebits_q;
      m1_d         = m1_q;
      acc_one_d    = acc_one_q;
      valid_d      = 1'b0;
      last_d       = 1'b0;
      result_d     = '0;
      eng_wr_ena   = 3'b000;
      eng_wr_x     = acc_word;
      eng_wr_y     = acc_word;
      eng_task_req = 1'b0;
      acc_we       = 1'b0;
      next_bit     = 1'b0;
`ifdef ME_CONST_TIME_EN
      ybit_d       = ybit_q;
      scr_we       = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (me_start && !valid_q) begin
               ebits_d   = (cfg_ebits > EB_W'(K*N)) ? EB_W'(K*N) : cfg_ebits;
               m1_d      = cfg_m1;
               cnt_d     = '0;
               acc_one_d = 1'b1;
               state_d   = S_LOAD_X;
            end
         end
         S_LOAD_X: begin
            if (me_x_valid) begin
               eng_wr_ena = 3'b111;
               eng_wr_x   = me_x;
               eng_wr_y   = rou_rd;
               cnt_d      = cnt_q + ADDR_W'(1);
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = S_MX_RUN;
               end
            end
         end
         S_MX_RUN: begin
            eng_task_req = 1'b1;
            if (eng_task_grant) cnt_d = cnt_q + ADDR_W'(1);
            if (eng_task_end) begin
               cnt_d = '0;
               if (ebits_q == '0) begin
                  state_d = S_FIN_WR;
               end else begin
                  idx_d   = ebits_q - EB_W'(1);
                  state_d = S_SQ_WR;
               end
            end
         end
         S_SQ_WR, S_ML_WR, S_FIN_WR: begin
            eng_wr_ena = 3'b011;
            if (state_q == S_ML_WR)  eng_wr_y = xr_rd;
            if (state_q == S_FIN_WR) eng_wr_y = (cnt_q == '0) ? K'(1) : '0;
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST) begin
               cnt_d = '0;
               case (state_q)
                  S_SQ_WR: state_d = S_SQ_RUN;
                  S_ML_WR: state_d = S_ML_RUN;
                  default: state_d = S_FIN_RUN;
               endcase
            end
         end
         S_SQ_RUN: begin
            eng_task_req = 1'b1;
            if (eng_task_grant) begin
               acc_we = 1'b1;
               cnt_d  = cnt_q + ADDR_W'(1);
            end
            if (eng_task_end) begin
               cnt_d     = '0;
               acc_one_d = 1'b0;
`ifdef ME_CONST_TIME_EN
               ybit_d  = ybit;
               state_d = S_ML_WR;
`else
               if (ybit) state_d = S_ML_WR;
               else      next_bit = 1'b1;
`endif
            end
         end
         S_ML_RUN: begin
            eng_task_req = 1'b1;
            if (eng_task_grant) begin
`ifdef ME_CONST_TIME_EN
               acc_we = ybit_q;
               scr_we = ~ybit_q;
`else
               acc_we = 1'b1;
`endif
               cnt_d = cnt_q + ADDR_W'(1);
            end
            if (eng_task_end) begin
               cnt_d    = '0;
               next_bit = 1'b1;
            end
         end
         S_FIN_RUN: begin
            eng_task_req = 1'b1;
            if (eng_task_grant) begin
               valid_d  = 1'b1;
               result_d = eng_task_res;
               last_d   = (cnt_q == LAST);
               cnt_d    = cnt_q + ADDR_W'(1);
            end
            if (eng_task_end) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (next_bit) begin
         if (idx_q == '0) begin
            state_d = S_FIN_WR;
         end else begin
            idx_d   = idx_q - EB_W'(1);
            state_d = S_SQ_WR;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         ebits_q   <= '0;
         m1_q      <= '0;
         acc_one_q <= 1'b0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         ebits_q   <= ebits_d;
         m1_q      <= m1_d;
         acc_one_q <= acc_one_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         result_q  <= result_d;
      end
   end

endmodule

// File: tb/tb_me_iddmm_rt.sv
// tb/tb_me_iddmm_rt.sv - directed and model-checked bench for me_iddmm_rt at K=16, N=2
module tb_me_iddmm_rt;
   import me_iddmm_pkg::*;

   localparam int K = 16;
   localparam int N = 2;
   localparam int BUDGET = 3000;
   localparam logic [31:0] M_VAL   = 32'hFFFFFFFB;
   localparam logic [31:0] ROU_VAL = 32'd25;
   localparam logic [31:0] ONE_VAL = 32'd5;
   localparam logic [15:0] M1_VAL  = 16'hCCCD;
   localparam longint unsigned MOD = 64'hFFFFFFFB;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_wr_en;
   logic [1:0]  cfg_sel;
   logic [0:0]  cfg_addr;
   logic [15:0] cfg_data, cfg_m1;
   logic [5:0]  cfg_ebits;
   logic        me_start, me_busy;
   logic [15:0] me_x, me_result;
   logic        me_x_valid, me_x_ready, me_valid, me_last;

   int total = 0;
   int bad = 0;
   int rdy_drop = 0;

   always #5 clk = ~clk;

   me_iddmm_rt #(.K(K), .N(N)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_wr_en(cfg_wr_en), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .cfg_m1(cfg_m1), .cfg_ebits(cfg_ebits), .me_start(me_start),
      .me_busy(me_busy), .me_x(me_x), .me_x_valid(me_x_valid), .me_x_ready(me_x_ready),
      .me_result(me_result), .me_valid(me_valid), .me_last(me_last));

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic [5:0]  eb;
      logic [31:0] exp_res;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp_v);
      end
   endtask

   function automatic logic [31:0] modexp(input logic [31:0] x, input logic [31:0] y, input int eb);
      longint unsigned r, b;
      int e;
      r = 1;
      b = {32'b0, x} % MOD;
      e = (eb > 32) ? 32 : eb;
      for (int i = e - 1; i >= 0; i--) begin
         r = (r * r) % MOD;
         if (y[i]) r = (r * b) % MOD;
      end
      return r[31:0];
   endfunction

   task automatic load_cfg(input logic [31:0] y);
      logic [31:0] v;
      for (int s = 0; s < 4; s++) begin
         case (s)
            0: v = M_VAL;
            1: v = ROU_VAL;
            2: v = ONE_VAL;
            default: v = y;
         endcase
         for (int a = 0; a < 2; a++) begin
            @(negedge clk);
            cfg_wr_en = 1'b1;
            cfg_sel   = s[1:0];
            cfg_addr  = a[0:0];
            cfg_data  = v[16*a +: 16];
         end
      end
      @(negedge clk);
      cfg_wr_en = 1'b0;
   endtask

   task automatic run(input logic [31:0] x, input logic [5:0] eb, input int gap, input bit poke,
                      output logic [31:0] res, output logic last_ok, output int cyc);
      int wi, gc, nw;
      bit pend;
      res = '0; last_ok = 1'b1; nw = 0; wi = 0; gc = 0; pend = 1'b0; cyc = 0;
      @(negedge clk);
      cfg_m1 = M1_VAL; cfg_ebits = eb; me_start = 1'b1;
      @(negedge clk);
      me_start = 1'b0;
      for (int t = 0; t < BUDGET && nw < 2; t++) begin
         if (pend) begin wi++; gc = gap; pend = 1'b0; end
         if (me_valid) begin
            res[16*nw +: 16] = me_result;
            if (me_last != (nw == 1)) last_ok = 1'b0;
            nw++;
         end
         if (wi < 2 && gc == 0) begin
            me_x_valid = 1'b1;
            me_x = x[16*wi +: 16];
         end else begin
            me_x_valid = 1'b0;
            if (gc > 0) gc--;
         end
         if (gap > 0 && wi == 1 && !me_x_valid && !me_x_ready) rdy_drop++;
         pend = me_x_valid && me_x_ready;
         if (poke && t == 6) begin
            me_start = 1'b1; cfg_wr_en = 1'b1; cfg_sel = CFG_M; cfg_addr = 1'b0; cfg_data = 16'h1234;
         end else begin
            me_start = 1'b0; cfg_wr_en = 1'b0;
         end
         cyc++;
         @(negedge clk);
      end
      me_x_valid = 1'b0;
      if (nw < 2) chk("run_timeout_words", nw, 2);
   endtask

   vec_t vecs[9];
   logic [31:0] res, exp_r;
   logic last_ok;
   int cyc, cyc_a, cyc_b, w;
   logic [31:0] rx, ry;

   initial begin
      vecs[0] = '{x: 32'd3,          y: 32'd5,   eb: 6'd3,  exp_res: 32'h000000F3};
      vecs[1] = '{x: 32'h12345678,   y: 32'd0,   eb: 6'd0,  exp_res: 32'd1};
      vecs[2] = '{x: 32'hFFFFFFFC,   y: 32'd1,   eb: 6'd1,  exp_res: 32'd1};
      vecs[3] = '{x: 32'd2,          y: 32'd10,  eb: 6'd4,  exp_res: 32'h00000400};
      vecs[4] = '{x: 32'd7,          y: 32'd2,   eb: 6'd2,  exp_res: 32'd49};
      vecs[5] = '{x: 32'hFFFFFFFA,   y: 32'd2,   eb: 6'd2,  exp_res: 32'd1};
      vecs[6] = '{x: 32'd3,          y: 32'd3,   eb: 6'd40, exp_res: 32'd27};
      vecs[7] = '{x: 32'd2,          y: 32'hD,   eb: 6'd3,  exp_res: 32'd32};
      vecs[8] = '{x: 32'd0,          y: 32'd5,   eb: 6'd3,  exp_res: 32'd0};

      rst_n = 1'b0; cfg_wr_en = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = '0;
      cfg_m1 = '0; cfg_ebits = '0; me_start = 1'b0; me_x = '0; me_x_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_busy",   me_busy,    0);
      chk("reset_ready",  me_x_ready, 0);
      chk("reset_valid",  me_valid,   0);
      chk("reset_last",   me_last,    0);
      chk("reset_result", me_result,  0);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         load_cfg(vecs[i].y);
         run(vecs[i].x, vecs[i].eb, 0, 1'b0, res, last_ok, cyc);
         chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
         chk($sformatf("vec%0d_last", i), last_ok, 1);
         chk($sformatf("vec%0d_busy_after", i), me_busy, 0);
      end

      load_cfg(32'd5);
      run(32'd3, 6'd3, 3, 1'b0, res, last_ok, cyc);
      chk("gap_result", res, 32'hF3);
      chk("gap_ready_drops", rdy_drop, 0);

      run(32'd3, 6'd3, 0, 1'b1, res, last_ok, cyc);
      chk("poke_result", res, 32'hF3);
      run(32'd3, 6'd3, 0, 1'b0, res, last_ok, cyc);
      chk("poke_banks_kept", res, 32'hF3);

      load_cfg(32'd0);
      @(negedge clk);
      cfg_m1 = M1_VAL; cfg_ebits = 6'd32; me_start = 1'b1;
      @(negedge clk);
      me_start = 1'b0; me_x = 16'd3; me_x_valid = 1'b1;
      w = 0;
      while (dut.state_q != S_SQ_RUN && w < 200) begin
         @(negedge clk);
         w++;
      end
      me_x_valid = 1'b0;
      chk("reach_sq_run", (w < 200), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy",   me_busy,    0);
      chk("midrst_valid",  me_valid,   0);
      chk("midrst_ready",  me_x_ready, 0);
      chk("midrst_result", me_result,  0);
      @(negedge clk);
      rst_n = 1'b1;
      load_cfg(32'd5);
      run(32'd3, 6'd3, 0, 1'b0, res, last_ok, cyc);
      chk("after_rst_result", res, 32'hF3);

      for (int i = 0; i < 40; i++) begin
         rx = $urandom;
         ry = $urandom;
         exp_r = modexp(rx, ry, 32);
         load_cfg(ry);
         run(rx, 6'd32, 0, 1'b0, res, last_ok, cyc);
         chk($sformatf("rand%0d x=%h y=%h", i, rx, ry), res, exp_r);
      end

`ifdef ME_CONST_TIME_EN
      load_cfg(32'd1);
      run(32'd7, 6'd32, 0, 1'b0, res, last_ok, cyc_a);
      chk("ct_y1_result", res, 32'd7);
      load_cfg(32'hFFFFFFFF);
      run(32'd7, 6'd32, 0, 1'b0, res, last_ok, cyc_b);
      chk("ct_yall_result", res, modexp(32'd7, 32'hFFFFFFFF, 32));
      chk("ct_cycles_equal", cyc_b, cyc_a);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
